// File: rtl/behavioral_wv_unit.sv
// W/V Boolean unit holding a gate-level and a behavioural copy of the same function.
// W/V come from the behavioural path; a sticky flag records any disagreement between the two copies.
module behavioral_wv_unit #(
  parameter bit OUT_REG = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic A,
  input  logic B,
  input  logic C,
  input  logic D,
  output logic W,
  output logic V,
  output logic mismatch
);

  // Structural copy: nets are kept explicit so a single net can be probed or overridden.
  wire n_b, ab_and, cd_and, gate_w;
  wire ab_or, cd_xor, cd_xnor, gate_v;

  not u_w_nb  (n_b,    B);
  and u_w_ab  (ab_and, A, n_b);
  and u_w_cd  (cd_and, C, D);
  or  u_w_or  (gate_w, ab_and, cd_and);

  or  u_v_ab  (ab_or,   A, B);
  xor u_v_cd  (cd_xor,  C, D);
  not u_v_nx  (cd_xnor, cd_xor);
  and u_v_and (gate_v,  ab_or, cd_xnor);

  logic beh_w, beh_v;
  assign beh_w = (A & ~B) | (C & D);
  assign beh_v = (A | B) & ~(C ^ D);

  logic mismatch_d, mismatch_q;

  always_comb begin
    mismatch_d = mismatch_q;
    if ((gate_w != beh_w) || (gate_v != beh_v)) mismatch_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mismatch_q <= 1'b0;
    else     mismatch_q <= mismatch_d;
  end

  assign mismatch = mismatch_q;

  generate
    if (OUT_REG) begin : g_reg
      logic w_d, v_d, w_q, v_q;

      always_comb begin
        w_d = beh_w;
        v_d = beh_v;
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          w_q <= 1'b0;
          v_q <= 1'b0;
        end else begin
          w_q <= w_d;
          v_q <= v_d;
        end
      end

      assign W = w_q;
      assign V = v_q;
    end else begin : g_comb
      // Reset still forces the outputs low in the combinational build.
      assign W = beh_w & ~rst;
      assign V = beh_v & ~rst;
    end
  endgenerate

endmodule

// File: tb/tb_behavioral_wv_unit.sv
// Bench for behavioral_wv_unit: registered and combinational builds side by side,
// directed vectors, full sweep, random vectors and a forced fault on the gate path.
module tb_behavioral_wv_unit;

  logic clk = 1'b0;
  logic rst;
  logic a, b, c, d;
  logic w1, v1, mm1;
  logic w0, v0, mm0;
  int   total = 0;
  int   bad   = 0;
  logic mm_exp;

  always #5 clk = ~clk;

  behavioral_wv_unit #(.OUT_REG(1'b1)) dut_reg (
    .clk(clk), .rst(rst), .A(a), .B(b), .C(c), .D(d),
    .W(w1), .V(v1), .mismatch(mm1)
  );

  behavioral_wv_unit #(.OUT_REG(1'b0)) dut_comb (
    .clk(clk), .rst(rst), .A(a), .B(b), .C(c), .D(d),
    .W(w0), .V(v0), .mismatch(mm0)
  );

  // Reference: W is true when A is set without B, or both C and D are set;
  // V is true when at least one of A/B is set and C, D agree.
  function automatic logic [1:0] ref_wv(input logic [3:0] abcd);
    int na, nb, nc, nd;
    logic rw, rv;
    na = abcd[3]; nb = abcd[2]; nc = abcd[1]; nd = abcd[0];
    rw = (na > nb) || (nc + nd == 2);
    rv = (na + nb > 0) && (nc == nd);
    return {rw, rv};
  endfunction

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Apply a vector at the falling edge, check the combinational build, then
  // check the registered build just after the next rising edge.
  task automatic step(input logic [3:0] abcd, input string tag);
    logic [1:0] e;
    @(negedge clk);
    {a, b, c, d} = abcd;
    e = ref_wv(abcd);
    #1;
    chk({tag, "_comb_w"}, w0, e[1]);
    chk({tag, "_comb_v"}, v0, e[0]);
    @(posedge clk);
    #1;
    chk({tag, "_reg_w"}, w1, e[1]);
    chk({tag, "_reg_v"}, v1, e[0]);
    chk({tag, "_mm_reg"}, mm1, mm_exp);
    chk({tag, "_mm_comb"}, mm0, 1'b0);
  endtask

  initial begin
    mm_exp = 1'b0;
    rst = 1'b1;
    {a, b, c, d} = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Load a non-zero result so the reset check below is meaningful.
    step(4'b1000, "pre");

    // Reset mid-operation: outputs drop at once, and edges under reset are ignored.
    @(negedge clk);
    {a, b, c, d} = 4'b1011;
    rst = 1'b1;
    #1;
    chk("rst_now_w", w1, 1'b0);
    chk("rst_now_v", v1, 1'b0);
    chk("rst_now_mm", mm1, 1'b0);
    chk("rst_now_comb_w", w0, 1'b0);
    @(posedge clk);
    #1;
    chk("rst_edge_w", w1, 1'b0);
    chk("rst_edge_v", v1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_rel_w", w1, 1'b1);
    chk("rst_rel_v", v1, 1'b1);
    chk("rst_rel_mm", mm1, 1'b0);

    step(4'b1000, "d1000");
    step(4'b0011, "d0011");
    step(4'b0110, "d0110");
    step(4'b0100, "d0100");
    step(4'b1101, "d1101");

    for (int i = 0; i < 16; i++) step(4'(i), $sformatf("sweep%0d", i));

    for (int i = 0; i < 20; i++) step(4'($urandom_range(0, 15)), $sformatf("rand%0d", i));

    // Fault on the structural V net for one edge: inputs 0000 make the true V zero.
    @(negedge clk);
    {a, b, c, d} = 4'b0000;
    force dut_reg.gate_v = 1'b1;
    @(posedge clk);
    #1;
    chk("fault_mm", mm1, 1'b1);
    chk("fault_v", v1, 1'b0);
    chk("fault_other_mm", mm0, 1'b0);
    @(negedge clk);
    release dut_reg.gate_v;
    mm_exp = 1'b1;
    for (int i = 0; i < 5; i++) step(4'($urandom_range(0, 15)), $sformatf("sticky%0d", i));

    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("clr_mm", mm1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    mm_exp = 1'b0;
    step(4'b1111, "post");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    bad++;
    $display("FAIL timeout observed=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/behavioral_wv_unit.md
Name: behavioral_wv_unit

Overview:
- Clocked 4-input, 2-output Boolean function unit: inputs A, B, C, D; outputs W, V.
- Internally it holds two implementations of the same function:
  - a gate-level netlist (AND/OR/NOT/XOR primitives only);
  - a behavioural expression path.
- It registers the W and V results and raises a sticky flag if the two paths ever disagree.
- It is the reference block for the structural-to-behavioural equivalence flow. A 20-vector random compare bench drives it in lockstep with its gate-level twin.

Parameters:
- OUT_REG, 1, 1 = W/V registered (latency 1 clk); 0 = W/V combinational from the current inputs. The mismatch flag is always registered.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- A  input  1  function input A
- B  input  1  function input B
- C  input  1  function input C
- D  input  1  function input D
- W  output  1  W = (A & ~B) | (C & D)
- V  output  1  V = (A | B) & ~(C ^ D)
- mismatch  output  1  sticky: gate-level and behavioural paths disagreed

Behaviour:
- Interface: one clock, clk; reset rst is asynchronous and active-high.
- Gate path (structural):
  - W: NOT B, AND2(A, nB), AND2(C, D), OR2.
  - V: OR2(A, B), XOR2(C, D), NOT, AND2.
- Behavioural path: the same W/V equations written as continuous expressions.
- OUT_REG=1:
  - On each rising clk, W and V load the behavioural-path results for the A..D values present at that edge.
  - Latency is 1 clock. Outputs hold between edges.
- OUT_REG=0: W and V follow the inputs combinationally, with zero latency.
- Mismatch:
  - On each rising clk, if gate W != behavioural W, or gate V != behavioural V, mismatch is set to 1.
  - Once set, mismatch stays 1 until rst.
- Reset:
  - rst=1 forces W=0, V=0, mismatch=0 immediately, without waiting for clk.
  - While rst=1, edges are ignored.
  - The first capture happens on the first rising edge after rst falls.
  - Reset mid-operation discards the pending result, and outputs read 0.
- X/Z inputs: no special handling. X propagates, and the mismatch compare treats X as not-equal only if `!==` semantics are enabled in simulation. Synthesis uses `!=`.
- No handshake. Every clock edge is a valid sample.
- Full truth table (ABCD -> WV): 0000->01? No: V=(A|B)&~(C^D). For ABCD=0000, A|B=0, so V=0, W=0 (00).
  - A|B=0 rows: W=C&D, V=0.
  - A=1,B=0: W=1.
  - Otherwise W=C&D.
  - V=1 iff (A|B) and C==D.

Test Plan:
- Reset: assert rst with inputs 1,0,1,1 -> W=0, V=0, mismatch=0 immediately. Release rst -> on the next edge W=1, V=1.
- A=1,B=0,C=0,D=0, clock once -> W=1, V=1, mismatch=0.
- A=0,B=0,C=1,D=1 -> W=1, V=0. Then A=0,B=1,C=1,D=0 -> W=0, V=0 on the following edge (1-cycle latency checked against the previous vector).
- A=0,B=1,C=0,D=0 -> W=0, V=1. A=1,B=1,C=0,D=1 -> W=0, V=0.
- Exhaustive sweep of all 16 ABCD codes, one per clock, in OUT_REG=1 and OUT_REG=0 builds -> W/V match the equations at each step and mismatch stays 0. Then 20 random vectors at a 10-time-unit spacing compared against the gate-level twin -> all equal.
- Fault injection: force the gate-path V net to 1 for one edge with ABCD=0000 -> mismatch=1. Remains 1 after the force is released and after 5 more clocks; clears only on rst.
